// File: rtl/dmem_pkg.sv
// Shared types and constants for the jacaranda-8 data-memory access controller.
package dmem_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    // Host request FIFO entry layout: {we, addr, wdata}
    localparam int unsigned WE_BIT   = 16;
    localparam int unsigned ADDR_MSB = 15;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned ENTRY_W  = 17;

    localparam int unsigned DEFAULT_DEPTH        = 4;
    localparam int unsigned DEFAULT_STARVE_LIMIT = 8;
    localparam int unsigned WAIT_W               = 4;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } host_req_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_CPU,
        GNT_HOST
    } grant_e;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Host request/response channel between the Caravel bridge and the access controller.
interface dmem_access_ctrl_if;
    import dmem_pkg::*;

    logic              host_valid;
    logic              host_ready;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output host_valid, host_we, host_addr, host_wdata,
        input  host_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_valid, host_we, host_addr, host_wdata,
        output host_ready, host_rvalid, host_rdata
    );

endinterface

// File: rtl/host_req_fifo.sv
// Synchronous request FIFO with a count-based full flag; head is valid whenever !empty.
module host_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = storage[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-port data-memory arbiter: CPU has priority, buffered host requests are
// forced through after STARVE_LIMIT denied cycles.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_w_data,
    input  logic              cpu_w_en,
    input  logic              cpu_r_en,
    output logic [DATA_W-1:0] cpu_r_data,
    output logic              cpu_stall,
    dmem_access_ctrl_if.slave host,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_w_en,
    input  logic [DATA_W-1:0] mem_r_data
);

    host_req_t          push_entry;
    host_req_t          head;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               cpu_req;
    logic               force_host;
    grant_e             grant;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_data;
    logic               host_read_gnt;

    assign push_entry = '{we: host.host_we, addr: host.host_addr, wdata: host.host_wdata};
    assign fifo_push  = host.host_valid && !fifo_full;
    assign fifo_pop   = (grant == GNT_HOST);
    assign head       = host_req_t'(head_bits);

    host_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head_bits)
    );

    assign host.host_ready  = !fifo_full;
    assign host.host_rvalid = rsp_valid;
    assign host.host_rdata  = rsp_data;
    assign cpu_r_data       = mem_r_data;

    // Grant: a starved host head preempts the CPU for exactly one cycle
    always_comb begin
        grant      = GNT_IDLE;
        cpu_stall  = 1'b0;
        cpu_req    = cpu_r_en | cpu_w_en;
        force_host = !fifo_empty && (wait_cnt == WAIT_W'(STARVE_LIMIT));
        if (force_host) begin
            grant     = GNT_HOST;
            cpu_stall = 1'b1;
        end else if (cpu_req) begin
            grant = GNT_CPU;
        end else if (!fifo_empty) begin
            grant = GNT_HOST;
        end
    end

    // Memory port mux; writes are suppressed while reset is held
    always_comb begin
        mem_addr   = cpu_addr;
        mem_w_data = cpu_w_data;
        mem_w_en   = 1'b0;
        case (grant)
            GNT_CPU:  mem_w_en = cpu_w_en;
            GNT_HOST: begin
                mem_addr   = head.addr;
                mem_w_data = head.wdata;
                mem_w_en   = head.we;
            end
            default:  mem_w_en = 1'b0;
        endcase
        if (reset) mem_w_en = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (fifo_empty || grant == GNT_HOST) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign host_read_gnt = (grant == GNT_HOST) && !head.we;

    // Read data is captured at the grant edge and presented for one cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= host_read_gnt;
            if (host_read_gnt) rsp_data <= mem_r_data;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 256x8 memory attached.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic       clock;
    logic       reset;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_w_data;
    logic       cpu_w_en;
    logic       cpu_r_en;
    logic [7:0] cpu_r_data;
    logic       cpu_stall;
    logic [7:0] mem_addr;
    logic [7:0] mem_w_data;
    logic       mem_w_en;
    logic [7:0] mem_r_data;

    dmem_access_ctrl_if host_bus ();

    dmem_access_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_w_data (cpu_w_data),
        .cpu_w_en   (cpu_w_en),
        .cpu_r_en   (cpu_r_en),
        .cpu_r_data (cpu_r_data),
        .cpu_stall  (cpu_stall),
        .host       (host_bus.slave),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_w_en   (mem_w_en),
        .mem_r_data (mem_r_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory model plus write/response activity logs
    logic [7:0] mem_model [256];
    int         wr_cnt = 0;
    int         rv_cnt = 0;
    logic [7:0] wlog [$];

    assign mem_r_data = mem_model[mem_addr];

    always @(posedge clock) begin
        if (mem_w_en) begin
            mem_model[mem_addr] <= mem_w_data;
            wr_cnt <= wr_cnt + 1;
            wlog.push_back(mem_addr);
        end
        if (host_bus.host_rvalid) rv_cnt <= rv_cnt + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       we;
        logic       re;
        logic [7:0] exp_maddr;
        logic       exp_wen;
        logic [7:0] exp_rdata;
        logic       chk_rd;
    } vec_t;

    vec_t vecs [9];

    logic [7:0] q_addr [5];
    logic [7:0] q_data [5];
    logic       q_we   [5];

    initial begin
        int wc0;
        int rc0;
        int w0;
        int grants;
        int waited;
        int waits [5];
        logic rdy;
        logic got;

        vecs[0] = '{8'h01, 8'h11, 1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0};
        vecs[1] = '{8'h02, 8'h22, 1'b1, 1'b0, 8'h02, 1'b1, 8'h00, 1'b0};
        vecs[2] = '{8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'h11, 1'b1};
        vecs[3] = '{8'h02, 8'h00, 1'b0, 1'b1, 8'h02, 1'b0, 8'h22, 1'b1};
        vecs[4] = '{8'h01, 8'hEE, 1'b1, 1'b0, 8'h01, 1'b1, 8'h00, 1'b0};
        vecs[5] = '{8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'hEE, 1'b1};
        vecs[6] = '{8'h02, 8'h5C, 1'b0, 1'b0, 8'h02, 1'b0, 8'h22, 1'b1};
        vecs[7] = '{8'hFF, 8'h80, 1'b1, 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0};
        vecs[8] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h80, 1'b1};

        q_addr = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h53};
        q_data = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'h00};
        q_we   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset      = 1'b1;
        cpu_addr   = 8'h00;
        cpu_w_data = 8'h00;
        cpu_w_en   = 1'b0;
        cpu_r_en   = 1'b0;
        host_bus.host_valid = 1'b0;
        host_bus.host_we    = 1'b0;
        host_bus.host_addr  = 8'h00;
        host_bus.host_wdata = 8'h00;

        // Reset state
        @(negedge clock);
        chk("rst_ready", host_bus.host_ready, 1);
        chk("rst_rvalid", host_bus.host_rvalid, 0);
        chk("rst_rdata", host_bus.host_rdata, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_wen", mem_w_en, 0);
        @(posedge clock); #1;
        reset = 1'b0;

        // CPU pass-through with an empty host queue
        for (int i = 0; i < 9; i++) begin
            cpu_addr   = vecs[i].addr;
            cpu_w_data = vecs[i].wdata;
            cpu_w_en   = vecs[i].we;
            cpu_r_en   = vecs[i].re;
            @(negedge clock);
            chk($sformatf("t%0d_maddr", i), mem_addr, vecs[i].exp_maddr);
            chk($sformatf("t%0d_wen", i), mem_w_en, vecs[i].exp_wen);
            chk($sformatf("t%0d_stall", i), cpu_stall, 0);
            if (vecs[i].exp_wen) chk($sformatf("t%0d_wdata", i), mem_w_data, vecs[i].wdata);
            if (vecs[i].chk_rd) chk($sformatf("t%0d_rdata", i), cpu_r_data, vecs[i].exp_rdata);
            @(posedge clock); #1;
        end
        cpu_w_en = 1'b0;
        cpu_r_en = 1'b0;

        // Host write 0x5A to 0x10 then read it back, CPU idle
        wc0 = wr_cnt;
        rc0 = rv_cnt;
        host_bus.host_valid = 1'b1;
        host_bus.host_we    = 1'b1;
        host_bus.host_addr  = 8'h10;
        host_bus.host_wdata = 8'h5A;
        @(posedge clock); #1;
        host_bus.host_we = 1'b0;
        @(negedge clock);
        chk("hw_wen", mem_w_en, 1);
        chk("hw_addr", mem_addr, 8'h10);
        chk("hw_wdata", mem_w_data, 8'h5A);
        @(posedge clock); #1;
        host_bus.host_valid = 1'b0;
        @(negedge clock);
        chk("hr_wen", mem_w_en, 0);
        chk("hr_addr", mem_addr, 8'h10);
        chk("hr_rvalid_early", host_bus.host_rvalid, 0);
        @(negedge clock);
        chk("hr_rvalid", host_bus.host_rvalid, 1);
        chk("hr_rdata", host_bus.host_rdata, 8'h5A);
        @(negedge clock);
        chk("hr_rvalid_pulse", host_bus.host_rvalid, 0);
        chk("hr_wr_count", wr_cnt - wc0, 1);
        chk("hr_rv_count", rv_cnt - rc0, 1);

        // Starvation: CPU stores every cycle while a host read waits
        @(posedge clock); #1;
        cpu_w_en   = 1'b1;
        cpu_addr   = 8'h20;
        cpu_w_data = 8'h33;
        host_bus.host_valid = 1'b1;
        host_bus.host_we    = 1'b0;
        host_bus.host_addr  = 8'h20;
        @(posedge clock); #1;
        host_bus.host_valid = 1'b0;
        grants = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (cpu_stall) break;
            grants++;
        end
        chk("sv_grants", grants, 8);
        chk("sv_stall_wen", mem_w_en, 0);
        chk("sv_stall_addr", mem_addr, 8'h20);
        @(negedge clock);
        chk("sv_rvalid", host_bus.host_rvalid, 1);
        chk("sv_rdata", host_bus.host_rdata, 8'h33);
        chk("sv_unstall", cpu_stall, 0);
        chk("sv_wait_cnt", dut.wait_cnt, 0);
        @(posedge clock); #1;
        cpu_w_en = 1'b0;

        // Five back-to-back host requests into a 4-deep queue, CPU loading
        cpu_r_en = 1'b1;
        cpu_addr = 8'h30;
        w0 = wlog.size();
        for (int i = 0; i < 5; i++) begin
            host_bus.host_valid = 1'b1;
            host_bus.host_we    = q_we[i];
            host_bus.host_addr  = q_addr[i];
            host_bus.host_wdata = q_data[i];
            waited = 0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clock);
                rdy = host_bus.host_ready;
                @(posedge clock); #1;
                if (rdy) break;
                waited++;
            end
            waits[i] = waited;
        end
        host_bus.host_valid = 1'b0;
        for (int i = 0; i < 4; i++) chk($sformatf("ff_wait%0d", i), waits[i], 0);
        chk("ff_wait4", waits[4], 6);
        got = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clock);
            if (host_bus.host_rvalid) begin
                got = 1'b1;
                break;
            end
        end
        chk("ff_rvalid_seen", got, 1);
        chk("ff_rdata", host_bus.host_rdata, 8'hC3);
        chk("ff_nwrites", wlog.size() - w0, 4);
        for (int i = 0; i < 4; i++) begin
            if (w0 + i < wlog.size()) chk($sformatf("ff_order%0d", i), wlog[w0 + i], q_addr[i]);
            else chk($sformatf("ff_order%0d", i), 32'hFFFF, q_addr[i]);
        end
        @(posedge clock); #1;
        cpu_r_en = 1'b0;

        // CPU load and host write to the same address pending together
        cpu_w_en   = 1'b1;
        cpu_addr   = 8'h40;
        cpu_w_data = 8'h12;
        @(posedge clock); #1;
        cpu_w_en = 1'b0;
        host_bus.host_valid = 1'b1;
        host_bus.host_we    = 1'b1;
        host_bus.host_addr  = 8'h40;
        host_bus.host_wdata = 8'h77;
        @(posedge clock); #1;
        host_bus.host_valid = 1'b0;
        cpu_r_en = 1'b1;
        @(negedge clock);
        chk("or_old_data", cpu_r_data, 8'h12);
        chk("or_cpu_wen", mem_w_en, 0);
        chk("or_cpu_stall", cpu_stall, 0);
        @(posedge clock); #1;
        cpu_r_en = 1'b0;
        @(negedge clock);
        chk("or_host_wen", mem_w_en, 1);
        chk("or_host_addr", mem_addr, 8'h40);
        chk("or_host_wdata", mem_w_data, 8'h77);
        @(posedge clock); #1;
        cpu_r_en = 1'b1;
        @(negedge clock);
        chk("or_new_data", cpu_r_data, 8'h77);
        @(posedge clock); #1;
        cpu_r_en = 1'b0;

        // Reset with three queued host writes and a CPU store held high
        cpu_r_en = 1'b1;
        cpu_addr = 8'h30;
        for (int i = 0; i < 3; i++) begin
            host_bus.host_valid = 1'b1;
            host_bus.host_we    = 1'b1;
            host_bus.host_addr  = 8'h60 + 8'(i);
            host_bus.host_wdata = 8'h99;
            @(posedge clock); #1;
        end
        host_bus.host_valid = 1'b0;
        @(negedge clock);
        reset      = 1'b1;
        cpu_r_en   = 1'b0;
        cpu_w_en   = 1'b1;
        cpu_addr   = 8'h70;
        cpu_w_data = 8'hAA;
        wc0 = wr_cnt;
        #1;
        chk("rq_wen", mem_w_en, 0);
        chk("rq_ready", host_bus.host_ready, 1);
        chk("rq_empty", dut.fifo_empty, 1);
        chk("rq_rvalid", host_bus.host_rvalid, 0);
        @(negedge clock);
        chk("rq_wen_held", mem_w_en, 0);
        @(posedge clock); #1;
        reset    = 1'b0;
        cpu_w_en = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        chk("rq_no_writes", wr_cnt - wc0, 0);

        // Reset during the grant cycle of a host read drops the response
        rc0 = rv_cnt;
        host_bus.host_valid = 1'b1;
        host_bus.host_we    = 1'b0;
        host_bus.host_addr  = 8'h10;
        @(posedge clock); #1;
        host_bus.host_valid = 1'b0;
        @(negedge clock);
        chk("rr_granted_addr", mem_addr, 8'h10);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("rr_rvalid", host_bus.host_rvalid, 0);
        chk("rr_rdata", host_bus.host_rdata, 0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rr_no_response", rv_cnt - rc0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
